// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared constants, state encoding and helpers for the
// serial CHIP-8 program loader.
//   Optional feature macro: CHIP8_LOADER_CSUM_EN (trailing checksum byte).
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_H,
    ST_LEN_L,
    ST_DATA,
    ST_CSUM,
    ST_FAIL
  } ld_state_e;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 12;
  localparam int unsigned DEF_BASE_ADDR  = 512;
  localparam int unsigned DEF_TIMEOUT    = 1200000;
  localparam logic [7:0]  DEF_SYNC_BYTE  = 8'hC8;

  // LEN field width on the wire (LEN_H low nibble + LEN_L)
  localparam int unsigned LEN_W = 12;

  // Legal payload length: non-zero and fits between base and top of memory
  function automatic logic len_ok(input logic [LEN_W-1:0] len,
                                  input int unsigned      max_len);
    return (len != '0) && (32'(len) <= max_len);
  endfunction

endpackage

// File: rtl/prog_loader_timer.sv
// loader_timer: reloadable down-counter guarding inter-byte idle time.
//   clk, rst     : clock, async active-high reset (counter cleared)
//   load_i       : reload to CYCLES-1 (byte strobe or idle)
//   expired_o    : high once CYCLES cycles have passed since the last load
module loader_timer #(
  parameter int unsigned CYCLES = 1200000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic expired_o
);
  localparam int unsigned W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Loaded with CYCLES-1 so that the count reaches zero on exactly the
  // CYCLES-th cycle after the loading strobe.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)            cnt_d = W'(CYCLES - 1);
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a framed program image from the UART byte stream
// and writes it into program memory starting at BASE_ADDR.
//   Frame: SYNC, LEN_H (low nibble), LEN_L, LEN payload bytes [, CSUM].
//   Optional feature macro: CHIP8_LOADER_CSUM_EN (adds the CSUM byte).
// Ports:
//   clk, rst        : clock, async active-high reset (aborts any frame)
//   rx_i, rx_i_v    : received byte and its single-cycle strobe
//   we, waddr, d    : registered memory write port, one pulse per payload byte
//   hold            : interpreter stall while a frame is in flight
//   done, err       : sticky status of the last frame (never both high)
//   count           : payload bytes written in the current/last frame
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned BASE_ADDR      = DEF_BASE_ADDR,
  parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_i,
  input  logic                  rx_i_v,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] d,
  output logic                  hold,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] count
);
  localparam int unsigned MAX_LEN = (1 << ADDR_WIDTH) - BASE_ADDR;

  ld_state_e             state_q;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic                  we_q, hold_q, done_q, err_q;
  logic                  tmr_expired;
`ifdef CHIP8_LOADER_CSUM_EN
  logic [7:0]            acc_q;
`endif

  assign len_d   = {len_q[LEN_W-1:8], rx_i};
  assign count_d = count_q + 1'b1;

  // Idle holds the timer loaded so a fresh frame always starts a full window
  loader_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (rx_i_v || (state_q == ST_IDLE)),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      d_q     <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CHIP8_LOADER_CSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      if (state_q == ST_FAIL) begin
        err_q   <= 1'b1;
        hold_q  <= 1'b0;
        state_q <= ST_IDLE;
      end else if (state_q != ST_IDLE && !rx_i_v && tmr_expired) begin
        // a strobe on the expiry cycle takes precedence over the timeout
        state_q <= ST_FAIL;
      end else if (rx_i_v) begin
        case (state_q)
          ST_IDLE: begin
            if (rx_i == SYNC_BYTE) begin
              state_q <= ST_LEN_H;
              hold_q  <= 1'b1;
              done_q  <= 1'b0;
              err_q   <= 1'b0;
              count_q <= '0;
`ifdef CHIP8_LOADER_CSUM_EN
              acc_q   <= '0;
`endif
            end
          end
          ST_LEN_H: begin
            len_q   <= {rx_i[3:0], 8'h00};
            state_q <= ST_LEN_L;
          end
          ST_LEN_L: begin
            len_q   <= len_d;
            state_q <= len_ok(len_d, MAX_LEN) ? ST_DATA : ST_FAIL;
          end
          ST_DATA: begin
            we_q    <= 1'b1;
            waddr_q <= ADDR_WIDTH'(BASE_ADDR) + count_q;
            d_q     <= DATA_WIDTH'(rx_i);
            count_q <= count_d;
`ifdef CHIP8_LOADER_CSUM_EN
            acc_q   <= acc_q + rx_i;
`endif
            if (count_d == ADDR_WIDTH'(len_q)) begin
`ifdef CHIP8_LOADER_CSUM_EN
              state_q <= ST_CSUM;
`else
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
`endif
            end
          end
`ifdef CHIP8_LOADER_CSUM_EN
          ST_CSUM: begin
            if (rx_i == acc_q) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= ST_FAIL;
            end
          end
`endif
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign d     = d_q;
  assign hold  = hold_q;
  assign done  = done_q;
  assign err   = err_q;
  assign count = count_q;

endmodule
